id_issue: RTL and testbench
===========================

# id_issue

Decode-to-execute issue register for the pipelined CPU. Takes one decoded instruction per cycle from ID, resolves operand forwarding from the EXE and MEM stages, and detects load-use hazards. It then registers the control and operand set that the execute stage consumes (`ealuc`, `eshift`, `ealuimm`, `eqa`, `eqb`, `eimm`) plus the write-back control that travels with it. It is the producer end of the EXE operand interface.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall counter.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_valid` in 1: ID holds a real instruction.
- `d_aluc` in 4, `d_shift` in 1, `d_aluimm` in 1: ALU control from decoder.
- `d_wreg` in 1, `d_m2reg` in 1, `d_wmem` in 1: register write, load, store.
- `d_rs` in 5, `d_rt` in 5: source register numbers.
- `d_usea` in 1, `d_useb` in 1: instruction reads rs / rt.
- `d_rn` in 5: destination register number.
- `d_qa` in 32, `d_qb` in 32: register-file read data.
- `d_imm` in 32: extended immediate / shift amount.
- `e_result` in 32: combinational ALU result of the instruction currently in EXE.
- `m_valid` in 1, `m_wreg` in 1, `m_rn` in 5: MEM-stage instruction status.
- `m_wdata` in 32: MEM-stage write-back value (load data already selected).
- `e_hold` in 1: downstream busy; freeze EXE registers.
- `flush` in 1: instruction in ID is wrong-path; do not issue it.
- `stall` out 1: combinational; ID and IF must hold this cycle.
- `evalid`, `ewreg`, `em2reg`, `ewmem` out 1 each: registered.
- `ern` out 5: registered.
- `ealuc` out 4: registered.
- `eshift`, `ealuimm` out 1 each: registered.
- `eqa`, `eqb`, `eimm` out 32 each: registered.
- `stall_cnt` out `CNT_W`: load-use bubble count, saturating.

## Operation
- **Forward A**, evaluated only when `d_usea` and `d_rs != 0`, first match wins:
  - If `evalid & ewreg & !em2reg & ern == d_rs`, then `e_result`.
  - Else if `m_valid & m_wreg & m_rn == d_rs`, then `m_wdata`.
  - Else `d_qa`.
  - If `d_usea` is 0 or `d_rs == 0`, use `d_qa` unmodified.
- **Forward B**: same rules with `d_rt`, `d_useb`, `d_qb`.
- **Load-use** (`lu`) = `d_valid & !flush & evalid & ewreg & em2reg & ern != 0 & ((d_usea & d_rs == ern) | (d_useb & d_rt == ern))`.
- **Stall**: `stall = e_hold | lu`.
- **Per-edge priority**: `rst` > `e_hold` > `flush` > `lu` > issue.
  - `rst`: every output register is 0 and `stall_cnt` is 0.
  - `e_hold`: all `e*` registers keep their value; the counter is unchanged.
  - `flush`, or `!d_valid`: issue a bubble. `evalid`, `ewreg` and `ewmem` are 0 and the other `e*` fields are don't-care; drive them to 0.
  - `lu`: issue a bubble as above, and increment `stall_cnt` unless it is all-ones.
  - Issue: `evalid` is 1, control fields copy the `d_*` inputs, `eqa`/`eqb` take the forwarded values, and `eimm` takes `d_imm`.
- `eqa`/`eqb` always carry register/forwarded data. The shift and immediate selection remains in EXE.

## Timing
- Latency: an instruction present on `d_*` at edge N appears on `e*` after edge N.
- Throughput: one instruction per cycle with no hazard.
- A load-use pair costs exactly one bubble. On the next cycle the load is in MEM and the value is forwarded via `m_wdata`.
- `stall` is combinational from `d_*`, the registered `e*` fields and `e_hold`, with no added register.
- Reset mid-stream: at the edge with `rst` high, all `e*` outputs and `stall_cnt` are 0. `stall` then depends only on `e_hold`.
- If `e_hold` and `flush` are asserted together, the hold wins. The EXE contents are preserved, and upstream keeps the ID instruction flushed.

## Test plan
- **Back-to-back ALU dependency.** Issue add r3 = 5 + 7. Next cycle, with `e_result = 12`, issue `d_rs = 3`, `d_qa = 0`. Required: `eqa = 12` after the edge, `stall = 0`.
- **MEM forward, and EXE-over-MEM priority.**
  - `m_rn = 4`, `m_wdata = 0x55`, `d_rs = 4`, no EXE match. Required: `eqa = 0x55`.
  - Also `ern = 4`, `ewreg = 1`, `e_result = 0x99`. Required: `eqa = 0x99`.
- **Load-use.** EXE holds a load to r5 (`em2reg = 1`); ID reads r5 via rt. Required:
  - `stall = 1` for one cycle.
  - Next `evalid = 0`.
  - `stall_cnt` goes 0 → 1.
  - The following cycle issues with `eqb = m_wdata`.
- **r0 and unused sources.** `d_rs = 0` while `ern = 0` with `ewreg = 1`, `e_result = 0xFF`: required `eqa = d_qa`. With `d_useb = 0` against a matching load: required `stall = 0`.
- **Hold and flush.** Assert `e_hold` for 3 cycles: the `e*` outputs are unchanged and `stall = 1`. Then assert `flush` with `d_valid = 1`: required `evalid = 0`, `ewreg = 0`, `ewmem = 0`.
- **Reset and saturation.**
  - With `CNT_W = 2`, force 5 load-use bubbles. Required: `stall_cnt = 3`.
  - Then assert `rst` for one cycle. Required: every output is 0 after the edge.

Source files
------------

// File: rtl/id_issue.sv
// Decode-to-execute issue register: resolves EXE/MEM operand forwarding,
// detects load-use hazards and registers the EXE-stage control/operand set.
module id_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [3:0]       d_aluc,
  input  logic             d_shift,
  input  logic             d_aluimm,
  input  logic             d_wreg,
  input  logic             d_m2reg,
  input  logic             d_wmem,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_usea,
  input  logic             d_useb,
  input  logic [4:0]       d_rn,
  input  logic [31:0]      d_qa,
  input  logic [31:0]      d_qb,
  input  logic [31:0]      d_imm,
  input  logic [31:0]      e_result,
  input  logic             m_valid,
  input  logic             m_wreg,
  input  logic [4:0]       m_rn,
  input  logic [31:0]      m_wdata,
  input  logic             e_hold,
  input  logic             flush,
  output logic             stall,
  output logic             evalid,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [4:0]       ern,
  output logic [3:0]       ealuc,
  output logic             eshift,
  output logic             ealuimm,
  output logic [31:0]      eqa,
  output logic [31:0]      eqb,
  output logic [31:0]      eimm,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        e_fwd_ok;
  logic        m_fwd_ok;
  logic        lu;

  // A load in EXE has no data yet, so it is never a forwarding source here.
  assign e_fwd_ok = evalid && ewreg && !em2reg;
  assign m_fwd_ok = m_valid && m_wreg;

  always_comb begin
    fwd_a = d_qa;
    if (d_usea && d_rs != 5'd0) begin
      if (e_fwd_ok && ern == d_rs)      fwd_a = e_result;
      else if (m_fwd_ok && m_rn == d_rs) fwd_a = m_wdata;
    end
  end

  always_comb begin
    fwd_b = d_qb;
    if (d_useb && d_rt != 5'd0) begin
      if (e_fwd_ok && ern == d_rt)      fwd_b = e_result;
      else if (m_fwd_ok && m_rn == d_rt) fwd_b = m_wdata;
    end
  end

  assign lu = d_valid && !flush && evalid && ewreg && em2reg && (ern != 5'd0) &&
              ((d_usea && d_rs == ern) || (d_useb && d_rt == ern));

  assign stall = e_hold || lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      evalid    <= 1'b0;
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ern       <= '0;
      ealuc     <= '0;
      eshift    <= 1'b0;
      ealuimm   <= 1'b0;
      eqa       <= '0;
      eqb       <= '0;
      eimm      <= '0;
      stall_cnt <= '0;
    end else if (!e_hold) begin
      if (flush || !d_valid || lu) begin
        evalid  <= 1'b0;
        ewreg   <= 1'b0;
        em2reg  <= 1'b0;
        ewmem   <= 1'b0;
        ern     <= '0;
        ealuc   <= '0;
        eshift  <= 1'b0;
        ealuimm <= 1'b0;
        eqa     <= '0;
        eqb     <= '0;
        eimm    <= '0;
        if (lu && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        evalid  <= 1'b1;
        ewreg   <= d_wreg;
        em2reg  <= d_m2reg;
        ewmem   <= d_wmem;
        ern     <= d_rn;
        ealuc   <= d_aluc;
        eshift  <= d_shift;
        ealuimm <= d_aluimm;
        eqa     <= fwd_a;
        eqb     <= fwd_b;
        eimm    <= d_imm;
      end
    end
  end

endmodule

// File: tb/tb_id_issue.sv
// Self-checking bench for id_issue: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the issue stage.
module tb_id_issue;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, d_valid, d_shift, d_aluimm, d_wreg, d_m2reg, d_wmem;
  logic        d_usea, d_useb, m_valid, m_wreg, e_hold, flush;
  logic [3:0]  d_aluc;
  logic [4:0]  d_rs, d_rt, d_rn, m_rn;
  logic [31:0] d_qa, d_qb, d_imm, e_result, m_wdata;

  logic          stall, evalid, ewreg, em2reg, ewmem, eshift, ealuimm;
  logic [4:0]    ern;
  logic [3:0]    ealuc;
  logic [31:0]   eqa, eqb, eimm;
  logic [CW-1:0] stall_cnt;

  id_issue #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_aluc(d_aluc), .d_shift(d_shift),
    .d_aluimm(d_aluimm), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_rs(d_rs), .d_rt(d_rt), .d_usea(d_usea), .d_useb(d_useb), .d_rn(d_rn),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .e_result(e_result),
    .m_valid(m_valid), .m_wreg(m_wreg), .m_rn(m_rn), .m_wdata(m_wdata),
    .e_hold(e_hold), .flush(flush), .stall(stall), .evalid(evalid),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern), .ealuc(ealuc),
    .eshift(eshift), .ealuimm(ealuimm), .eqa(eqa), .eqb(eqb), .eimm(eimm),
    .stall_cnt(stall_cnt)
  );

  int tests = 0;
  int fails = 0;
  logic last_stall;

  // Model of what EXE must hold; the counter is a plain integer.
  logic        x_valid, x_wreg, x_m2reg, x_wmem, x_shift, x_aluimm;
  logic [4:0]  x_rn;
  logic [3:0]  x_aluc;
  logic [31:0] x_qa, x_qb, x_imm;
  int          x_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic use_r, input logic [4:0] r, input logic [31:0] q);
    if (!use_r || r == 5'd0) return q;
    if (x_valid && x_wreg && !x_m2reg && x_rn == r) return e_result;
    if (m_valid && m_wreg && m_rn == r) return m_wdata;
    return q;
  endfunction

  function automatic logic lu_model();
    logic reads_load;
    reads_load = (d_usea && d_rs == x_rn) || (d_useb && d_rt == x_rn);
    return d_valid && !flush && x_valid && x_wreg && x_m2reg && x_rn != 5'd0 && reads_load;
  endfunction

  task automatic model_clear();
    x_valid = 0; x_wreg = 0; x_m2reg = 0; x_wmem = 0; x_shift = 0; x_aluimm = 0;
    x_rn = '0; x_aluc = '0; x_qa = '0; x_qb = '0; x_imm = '0;
  endtask

  task automatic model_edge();
    logic [31:0] na, nb;
    logic lu;
    na = fwd(d_usea, d_rs, d_qa);
    nb = fwd(d_useb, d_rt, d_qb);
    lu = lu_model();
    if (rst) begin
      model_clear();
      x_cnt = 0;
    end else if (e_hold) begin
      // EXE frozen
    end else if (flush || !d_valid || lu) begin
      model_clear();
      if (lu && x_cnt < CNT_MAX) x_cnt = x_cnt + 1;
    end else begin
      x_valid = 1; x_wreg = d_wreg; x_m2reg = d_m2reg; x_wmem = d_wmem;
      x_shift = d_shift; x_aluimm = d_aluimm; x_rn = d_rn; x_aluc = d_aluc;
      x_qa = na; x_qb = nb; x_imm = d_imm;
    end
  endtask

  // One cycle: check stall mid-cycle, clock, then check registered outputs.
  task automatic step();
    #3;
    last_stall = stall;
    chk("stall", stall, e_hold || lu_model());
    @(posedge clk);
    model_edge();
    #1;
    chk("evalid", evalid, x_valid);
    chk("ewreg", ewreg, x_wreg);
    chk("em2reg", em2reg, x_m2reg);
    chk("ewmem", ewmem, x_wmem);
    chk("ern", ern, x_rn);
    chk("ealuc", ealuc, x_aluc);
    chk("eshift", eshift, x_shift);
    chk("ealuimm", ealuimm, x_aluimm);
    chk("eqa", eqa, x_qa);
    chk("eqb", eqb, x_qb);
    chk("eimm", eimm, x_imm);
    chk("stall_cnt", stall_cnt, x_cnt);
  endtask

  task automatic idle_inputs();
    rst = 0; d_valid = 0; d_aluc = 0; d_shift = 0; d_aluimm = 0; d_wreg = 0;
    d_m2reg = 0; d_wmem = 0; d_rs = 0; d_rt = 0; d_usea = 0; d_useb = 0; d_rn = 0;
    d_qa = 0; d_qb = 0; d_imm = 0; e_result = 0; m_valid = 0; m_wreg = 0;
    m_rn = 0; m_wdata = 0; e_hold = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ua,
                       input logic ub, input logic [4:0] rn, input logic ld);
    d_valid = 1; d_rs = rs; d_rt = rt; d_usea = ua; d_useb = ub; d_rn = rn;
    d_wreg = 1; d_m2reg = ld; d_wmem = 0; d_aluc = 4'd2;
  endtask

  logic        sv_valid;
  logic [31:0] sv_qa;

  initial begin
    idle_inputs();
    model_clear();
    x_cnt = 0;

    rst = 1; step();
    chk("reset_evalid", evalid, 0);
    chk("reset_cnt", stall_cnt, 0);
    rst = 0;

    // back-to-back ALU dependency
    issue(5'd1, 5'd2, 1, 1, 5'd3, 0); d_qa = 5; d_qb = 7; step();
    issue(5'd3, 5'd2, 1, 1, 5'd6, 0); d_qa = 0; e_result = 12; step();
    chk("b2b_eqa", eqa, 32'd12);
    chk("b2b_stall", last_stall, 0);

    // MEM forward, then EXE over MEM
    m_valid = 1; m_wreg = 1; m_rn = 5'd4; m_wdata = 32'h55;
    issue(5'd4, 5'd0, 1, 0, 5'd4, 0); d_qa = 32'h1; step();
    chk("mem_fwd_eqa", eqa, 32'h55);
    e_result = 32'h99; step();
    chk("exe_pri_eqa", eqa, 32'h99);

    // load-use on rt
    m_valid = 0;
    issue(5'd0, 5'd0, 0, 0, 5'd5, 1); step();
    issue(5'd1, 5'd5, 0, 1, 5'd7, 0); d_qb = 0; step();
    chk("lu_stall", last_stall, 1);
    chk("lu_bubble", evalid, 0);
    chk("lu_cnt", stall_cnt, 1);
    m_valid = 1; m_wreg = 1; m_rn = 5'd5; m_wdata = 32'hABCD; step();
    chk("lu_after_stall", last_stall, 0);
    chk("lu_after_eqb", eqb, 32'hABCD);
    m_valid = 0;

    // r0 never forwards; unused source never stalls
    issue(5'd0, 5'd0, 0, 0, 5'd0, 0); step();
    issue(5'd0, 5'd0, 1, 0, 5'd8, 0); d_qa = 32'h1234; e_result = 32'hFF; step();
    chk("r0_eqa", eqa, 32'h1234);
    issue(5'd0, 5'd0, 0, 0, 5'd5, 1); step();
    issue(5'd2, 5'd5, 1, 0, 5'd9, 0); step();
    chk("unused_stall", last_stall, 0);

    // hold for 3 cycles then flush
    sv_valid = x_valid; sv_qa = x_qa;
    e_hold = 1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd3, 5'd4, 1, 1, 5'd10 + 5'(i), 0); d_qa = 32'hDEAD0000 + i;
      step();
      chk("hold_stall", last_stall, 1);
      chk("hold_evalid", evalid, sv_valid);
      chk("hold_eqa", eqa, sv_qa);
    end
    e_hold = 0; flush = 1; d_wmem = 1; step();
    chk("flush_evalid", evalid, 0);
    chk("flush_ewreg", ewreg, 0);
    chk("flush_ewmem", ewmem, 0);
    flush = 0;

    // saturation after 5 load-use bubbles, then reset
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      issue(5'd0, 5'd0, 0, 0, 5'd6, 1); step();
      issue(5'd6, 5'd0, 1, 0, 5'd7, 0); step();
    end
    chk("sat_cnt", stall_cnt, 3);
    rst = 1; step(); rst = 0;
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ern", ern, 0);
    chk("rst_eqb", eqb, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      e_hold   = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      d_valid  = ($urandom_range(0, 7) != 0);
      d_aluc   = 4'($urandom);
      d_shift  = 1'($urandom);
      d_aluimm = 1'($urandom);
      d_wreg   = ($urandom_range(0, 3) != 0);
      d_m2reg  = ($urandom_range(0, 2) == 0);
      d_wmem   = 1'($urandom);
      d_rs     = 5'($urandom_range(0, 7));
      d_rt     = 5'($urandom_range(0, 7));
      d_usea   = ($urandom_range(0, 3) != 0);
      d_useb   = 1'($urandom);
      d_rn     = 5'($urandom_range(0, 7));
      d_qa     = $urandom;
      d_qb     = $urandom;
      d_imm    = $urandom;
      e_result = $urandom;
      m_valid  = 1'($urandom);
      m_wreg   = 1'($urandom);
      m_rn     = 5'($urandom_range(0, 7));
      m_wdata  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
